// File: rtl/alu_pkg.sv
// Shared widths, flag vector type and flag bit positions for the ALU result collector.
package alu_pkg;
  localparam int OPCODE_W = 3;
  localparam int DATA_W   = 8;
  localparam int FLAG_W   = 4;
  localparam int ENTRY_W  = OPCODE_W + DATA_W + FLAG_W;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_NEG   = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  function automatic flags_t pack_flags(input logic carry, input logic zero,
                                        input logic ovf, input logic neg);
    flags_t f;
    f             = '0;
    f[FLAG_CARRY] = carry;
    f[FLAG_ZERO]  = zero;
    f[FLAG_OVF]   = ovf;
    f[FLAG_NEG]   = neg;
    return f;
  endfunction
endpackage

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO; head is read straight from registered storage.
// Handshake: a write happens when wr_valid_i && wr_ready_o, a read when rd_valid_o && rd_ready_i, both at clk rise.
module alu_result_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     push_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Ready depends on rst so nothing is taken during reset.
  assign wr_ready_o = !rst && (count_q < CW'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i && !rst;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign push_o     = push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU results with flags into a FWFT FIFO, counts accepted entries.
// Optional sticky flag accumulation is enabled by defining ALU_COLLECTOR_STICKY_EN.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic [DATA_W-1:0]      in_result,
  input  logic                   in_carry_out,
  input  logic                   in_zero,
  input  logic                   in_overflow,
  input  logic                   in_negative,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPCODE_W-1:0]    out_opcode,
  output logic [DATA_W-1:0]      out_result,
  output logic [FLAG_W-1:0]      out_flags,
  output logic [FLAG_W-1:0]      sticky_flags,
  input  logic                   sticky_clr,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             accepted
);
  flags_t             in_flags;
  logic [ENTRY_W-1:0] wr_data, rd_data;
  logic               push;
  logic [7:0]         accepted_q, accepted_d;

  assign in_flags = pack_flags(in_carry_out, in_zero, in_overflow, in_negative);
  assign wr_data  = {in_opcode, in_result, in_flags};

  alu_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  (wr_data),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (rd_data),
    .count_o    (count),
    .push_o     (push)
  );

  assign out_opcode = rd_data[ENTRY_W-1 -: OPCODE_W];
  assign out_result = rd_data[FLAG_W +: DATA_W];
  assign out_flags  = rd_data[FLAG_W-1:0];

  assign accepted_d = push ? accepted_q + 8'd1 : accepted_q;
  assign accepted   = accepted_q;

  always_ff @(posedge clk) begin
    if (rst) accepted_q <= '0;
    else     accepted_q <= accepted_d;
  end

`ifdef ALU_COLLECTOR_STICKY_EN
  flags_t sticky_q, sticky_d;

  // A clear coincident with a push leaves exactly the pushed flags.
  always_comb begin
    sticky_d = sticky_clr ? '0 : sticky_q;
    if (push) sticky_d = sticky_d | in_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = '0;
`endif
endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed table, corner sequences, random vs queue model.
module tb_alu_result_collector;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready;
  logic [2:0]    in_opcode = '0;
  logic [7:0]    in_result = '0;
  logic          in_carry_out = 1'b0, in_zero = 1'b0, in_overflow = 1'b0, in_negative = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [2:0]    out_opcode;
  logic [7:0]    out_result;
  logic [3:0]    out_flags, sticky_flags;
  logic          sticky_clr = 1'b0;
  logic [CW-1:0] count;
  logic [7:0]    accepted;

  alu_result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result),
    .in_carry_out(in_carry_out), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_negative(in_negative), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_result(out_result), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .count(count),
    .accepted(accepted)
  );

  // scoreboard / reference model: entry = {opcode, result, flags}
  logic [14:0] exp_q[$];
  logic [7:0]  m_acc = '0;
  logic [3:0]  m_sticky = '0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic drive(input logic iv, input logic [2:0] op, input logic [7:0] res,
                       input logic [3:0] fl, input logic ordy, input logic clr);
    in_valid     = iv;
    in_opcode    = op;
    in_result    = res;
    in_carry_out = fl[3];
    in_zero      = fl[2];
    in_overflow  = fl[1];
    in_negative  = fl[0];
    out_ready    = ordy;
    sticky_clr   = clr;
  endtask

  task automatic model_edge();
    logic do_push, do_pop;
    logic [3:0] fl;
    fl = {in_carry_out, in_zero, in_overflow, in_negative};
    if (rst) begin
      exp_q.delete();
      m_acc    = '0;
      m_sticky = '0;
    end else begin
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({in_opcode, in_result, fl});
        m_acc = m_acc + 8'd1;
      end
`ifdef ALU_COLLECTOR_STICKY_EN
      if (sticky_clr) m_sticky = do_push ? fl : 4'b0000;
      else if (do_push) m_sticky = m_sticky | fl;
`endif
    end
  endtask

  task automatic compare_model();
    check("count", 32'(count), 32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(!rst && exp_q.size() < DEPTH));
    check("accepted", 32'(accepted), 32'(m_acc));
    check("sticky", 32'(sticky_flags), 32'(m_sticky));
    if (exp_q.size() > 0) check("head", 32'({out_opcode, out_result, out_flags}), 32'(exp_q[0]));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [2:0] op;
    logic [7:0] res;
    logic       ordy;
    int         e_cnt;
    logic       e_ov;
    logic [7:0] e_head;
    logic       e_ird;
    int         e_acc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // single push after reset, then the fill/overflow/drain sequence
    vecs[0]  = '{1, 3'd0, 8'h02, 0, 1, 1, 8'h02, 1, 1};
    vecs[1]  = '{0, 3'd0, 8'h00, 1, 0, 0, 8'h00, 1, 1};
    vecs[2]  = '{1, 3'd1, 8'h10, 0, 1, 1, 8'h10, 1, 2};
    vecs[3]  = '{1, 3'd2, 8'h11, 0, 2, 1, 8'h10, 1, 3};
    vecs[4]  = '{1, 3'd3, 8'h12, 0, 3, 1, 8'h10, 1, 4};
    vecs[5]  = '{1, 3'd4, 8'h13, 0, 4, 1, 8'h10, 0, 5};
    vecs[6]  = '{1, 3'd5, 8'h14, 0, 4, 1, 8'h10, 0, 5};
    vecs[7]  = '{1, 3'd5, 8'h14, 1, 3, 1, 8'h11, 1, 5};
    vecs[8]  = '{1, 3'd5, 8'h14, 0, 4, 1, 8'h11, 0, 6};
    vecs[9]  = '{0, 3'd0, 8'h00, 1, 3, 1, 8'h12, 1, 6};
    vecs[10] = '{0, 3'd0, 8'h00, 1, 2, 1, 8'h13, 1, 6};
    vecs[11] = '{0, 3'd0, 8'h00, 1, 1, 1, 8'h14, 1, 6};
    vecs[12] = '{0, 3'd0, 8'h00, 1, 0, 0, 8'h00, 1, 6};

    #1;
    do_reset();
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_accepted", 32'(accepted), 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, vecs[i].op, vecs[i].res, 4'b0000, vecs[i].ordy, 0);
      cycle();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ird));
      check($sformatf("vec%0d_accepted", i), 32'(accepted), 32'(vecs[i].e_acc));
      if (vecs[i].e_ov) check($sformatf("vec%0d_head", i), 32'(out_result), 32'(vecs[i].e_head));
    end

    // steady push+pop at half full across pointer wrap
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 3'(i), 8'(8'h40 + i), 4'(i), 0, 0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1, 0);
      cycle();
      check("halffull_count", 32'(count), 2);
    end
    drive(0, 0, 0, 0, 1, 0);
    cycle();
    cycle();

    // sticky flags
    do_reset();
    drive(1, 0, 8'h01, 4'b1000, 1, 0);
    cycle();
    drive(1, 0, 8'h02, 4'b0010, 1, 0);
    cycle();
`ifdef ALU_COLLECTOR_STICKY_EN
    check("sticky_acc", 32'(sticky_flags), 32'h0000000a);
`else
    check("sticky_off", 32'(sticky_flags), 0);
`endif
    drive(1, 0, 8'h03, 4'b0001, 1, 1);
    cycle();
`ifdef ALU_COLLECTOR_STICKY_EN
    check("sticky_clr_push", 32'(sticky_flags), 32'h00000001);
`else
    check("sticky_off_clr", 32'(sticky_flags), 0);
`endif
    drive(0, 0, 0, 0, 1, 1);
    cycle();

    // reset mid-operation with push and pop requested
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i), 8'(8'h60 + i), 4'b1111, 0, 0);
      cycle();
    end
    rst = 1'b1;
    drive(1, 3'd7, 8'h77, 4'b1111, 1, 0);
    cycle();
    check("midrst_count", 32'(count), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_accepted", 32'(accepted), 0);
    check("midrst_sticky", 32'(sticky_flags), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("postrst_in_ready", 32'(in_ready), 1);
    cycle();

    // accepted counter wrap
    do_reset();
    for (int i = 0; i < 257; i++) begin
      drive(1, 3'(i), 8'(i), 4'(i), 1, 0);
      cycle();
    end
    check("acc_wrap", 32'(accepted), 1);
    drive(0, 0, 0, 0, 1, 0);
    cycle();

    // random traffic against the queue model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 The block SHALL have one parameter: DEPTH, 4, FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  ALU result presented.
REQ-005 in_ready  output  1  collector can accept.
REQ-006 in_opcode  input  3  opcode that produced the result.
REQ-007 in_result  input  8  ALU result.
REQ-008 in_carry_out, in_zero, in_overflow, in_negative  input  1 each  ALU flags.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer takes head entry.
REQ-011 out_opcode  output  3; out_result  output  8; out_flags  output  4  {carry_out, zero, overflow, negative} of head entry.
REQ-012 sticky_flags  output  4  OR-accumulated flags, same bit order.
REQ-013 sticky_clr  input  1  clear sticky_flags.
REQ-014 count  output  clog2(DEPTH)+1  current occupancy.
REQ-015 accepted  output  8  total accepted entries, wraps modulo 256.

Function
REQ-016 Push SHALL occur when in_valid and in_ready are both 1 at a clock edge; in_ready SHALL be 1 exactly when count < DEPTH and rst is 0.
REQ-017 Pop SHALL occur when out_valid and out_ready are both 1 at a clock edge; out_valid SHALL be 1 exactly when count > 0.
REQ-018 Outputs SHALL be first-word-fall-through from registered storage: a push into an empty FIFO at edge N gives out_valid=1 with that entry from edge N+1; no combinational input-to-output bypass.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, dequeue head, enqueue new entry in order.
REQ-020 When full, in_ready=0; an in_valid at that cycle SHALL NOT be stored, even if a pop occurs the same cycle.
REQ-021 When empty, out_ready SHALL have no effect; out_opcode/out_result/out_flags are don't-care while out_valid=0.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO across wrap.
REQ-023 accepted SHALL increment by 1 on every push, 255 -> 0.
REQ-024 Held inputs while in_ready=0 SHALL be accepted unchanged once in_ready rises (no loss, no duplication).

Reset
REQ-025 While rst=1 at an edge: count=0, pointers=0, accepted=0, sticky_flags=0, out_valid=0; in_ready SHALL be 0 during rst.
REQ-026 Reset mid-operation SHALL discard all stored entries; a push or pop coincident with rst SHALL be ignored.

Configuration
REQ-027 Macro ALU_COLLECTOR_STICKY_EN SHALL gate sticky-flag logic.
REQ-028 With ALU_COLLECTOR_STICKY_EN defined: each push SHALL OR its flags into sticky_flags; sticky_clr clears them; sticky_clr coincident with push SHALL yield exactly the pushed entry's flags.
REQ-029 Without ALU_COLLECTOR_STICKY_EN: sticky_flags SHALL be constant 0, sticky_clr ignored, no sticky registers inferred.

Structure
REQ-030 Shared package alu_pkg SHALL hold opcode width (3), data width (8), flag vector typedef (4 bits) and flag bit index constants (CARRY=3, ZERO=2, OVF=1, NEG=0).
REQ-031 Storage and pointers SHALL live in one sub-module alu_result_fifo (parameterised width/depth, FWFT); flag packing, sticky logic and accepted counter stay in the top.

Verification
REQ-032 Reset, then push opcode 0, result 0x02, flags 0000 -> out_valid=1 next cycle, out_result=0x02, count=1, accepted=1.
REQ-033 DEPTH=4, out_ready=0, push 5 entries 0x10..0x14 -> in_ready=0 after 4th, count=4, pop order 0x10..0x13, 0x14 accepted only after first pop.
REQ-034 Continuous push+pop for 10 cycles at half-full (count=2) -> count stays 2, outputs strictly in order across pointer wrap.
REQ-035 STICKY_EN: push flags 1000 then 0010 -> sticky_flags=1010; sticky_clr with push of 0001 -> sticky_flags=0001; without macro -> sticky_flags=0000 throughout.
REQ-036 Fill 3 entries then assert rst one cycle with in_valid=1 and out_ready=1 -> count=0, out_valid=0, accepted=0, sticky_flags=0; in_ready=1 the cycle after rst deasserts.
REQ-037 Push 257 entries with out_ready=1 -> accepted=1 after final push.
